// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - branch/jump resolution sequencer: compare, redirect, flush hold
// Operands are latched on accept so the shared comparator and target adder see stable values.
module branch_resolve_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [2:0]      br_mode,
    input  logic            br_jump,
    input  logic            br_jalr,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_offset,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic [XLEN-1:0] cmp_in_0,
    output logic [XLEN-1:0] cmp_in_1,
    output logic [2:0]      cmp_mode,
    input  logic            cmp_branch,
    input  logic            kill,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            misalign,
    output logic [31:0]     taken_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_REDIRECT,
        S_FLUSH
    } state_t;

    state_t            state_q;
    logic [2:0]        mode_q;
    logic              jump_q;
    logic              jalr_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   off_q;
    logic [XLEN-1:0]   rs1_q;
    logic [XLEN-1:0]   rs2_q;
    logic              redirect_valid_q;
    logic [XLEN-1:0]   redirect_pc_q;
    logic              flush_q;
    logic              misalign_q;
    logic [3:0]        flush_cnt_q;
    logic [31:0]       taken_count_q;

    logic              taken_d;
    logic [XLEN-1:0]   target_base_d;
    logic [XLEN-1:0]   target_sum_d;
    logic [XLEN-1:0]   target_d;

    // JALR clears bit 0 of the sum; the adder wraps modulo 2^XLEN.
    always_comb begin
        taken_d       = jump_q | cmp_branch;
        target_base_d = jalr_q ? rs1_q : pc_q;
        target_sum_d  = target_base_d + off_q;
        target_d      = jalr_q ? {target_sum_d[XLEN-1:1], 1'b0} : target_sum_d;
    end

    // Gated by rst_n so no request is signalled as accepted while reset is held.
    assign br_ready       = (state_q == S_IDLE) & ~kill & rst_n;

    assign cmp_in_0       = rs1_q;
    assign cmp_in_1       = rs2_q;
    assign cmp_mode       = mode_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign misalign       = misalign_q;
    assign taken_count    = taken_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            mode_q           <= '0;
            jump_q           <= 1'b0;
            jalr_q           <= 1'b0;
            pc_q             <= '0;
            off_q            <= '0;
            rs1_q            <= '0;
            rs2_q            <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            misalign_q       <= 1'b0;
            flush_cnt_q      <= '0;
            taken_count_q    <= '0;
        end else begin
            redirect_valid_q <= 1'b0;
            misalign_q       <= 1'b0;
            if (kill) begin
                state_q <= S_IDLE;
                flush_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (br_valid) begin
                            mode_q  <= br_mode;
                            jump_q  <= br_jump;
                            jalr_q  <= br_jalr;
                            pc_q    <= br_pc;
                            off_q   <= br_offset;
                            rs1_q   <= rs1_val;
                            rs2_q   <= rs2_val;
                            state_q <= S_COMPARE;
                        end
                    end
                    S_COMPARE: begin
                        if (!taken_d) begin
                            state_q <= S_IDLE;
                        end else if (target_d[1]) begin
                            misalign_q <= 1'b1;
                            state_q    <= S_IDLE;
                        end else begin
                            redirect_valid_q <= 1'b1;
                            redirect_pc_q    <= target_d;
                            flush_q          <= 1'b1;
                            taken_count_q    <= taken_count_q + 32'd1;
                            state_q          <= S_REDIRECT;
                        end
                    end
                    S_REDIRECT: begin
                        // The redirect cycle already counts as the first flush cycle.
                        if (FLUSH_CYCLES == 1) begin
                            flush_q <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            flush_cnt_q <= 4'(FLUSH_CYCLES - 1);
                            state_q     <= S_FLUSH;
                        end
                    end
                    S_FLUSH: begin
                        if (flush_cnt_q == 4'd1) begin
                            flush_q <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            flush_cnt_q <= flush_cnt_q - 4'd1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        flush_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - directed and randomized bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_mode;
    logic        br_jump;
    logic        br_jalr;
    logic [31:0] br_pc;
    logic [31:0] br_offset;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] cmp_in_0;
    logic [31:0] cmp_in_1;
    logic [2:0]  cmp_mode;
    logic        cmp_branch;
    logic        kill;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        misalign;
    logic [31:0] taken_count;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_count = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.XLEN(32), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n),
        .br_valid(br_valid), .br_ready(br_ready), .br_mode(br_mode),
        .br_jump(br_jump), .br_jalr(br_jalr), .br_pc(br_pc), .br_offset(br_offset),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .cmp_in_0(cmp_in_0), .cmp_in_1(cmp_in_1), .cmp_mode(cmp_mode),
        .cmp_branch(cmp_branch), .kill(kill),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush), .misalign(misalign), .taken_count(taken_count)
    );

    // RV32I funct3 comparisons; anything else compares false.
    function automatic logic cmp_model(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
        case (m)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    assign cmp_branch = cmp_model(cmp_mode, cmp_in_0, cmp_in_1);

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // kill_k: cycle after accept (1=compare) in which kill is held high; 0 = never.
    task automatic run_br(input logic [2:0] mode, input logic jump, input logic jalr,
                          input logic [31:0] pc, input logic [31:0] off,
                          input logic [31:0] a, input logic [31:0] b, input int kill_k);
        logic        taken, mis, e_ready, e_rv, e_fl, e_mis, killed;
        logic [31:0] tgt;
        taken = jump | cmp_model(mode, a, b);
        tgt   = jalr ? ((a + off) & 32'hFFFF_FFFE) : (pc + off);
        mis   = taken & tgt[1];
        @(negedge clk);
        br_valid = 1'b1; br_mode = mode; br_jump = jump; br_jalr = jalr;
        br_pc = pc; br_offset = off; rs1_val = a; rs2_val = b; kill = 1'b0;
        #1 chk_eq("accept_ready", br_ready, 1);
        for (int c = 1; c <= 2 + FC; c++) begin
            @(negedge clk);
            br_valid = 1'b0; br_mode = 3'($urandom); br_jump = 1'($urandom); br_jalr = 1'($urandom);
            br_pc = $urandom; br_offset = $urandom; rs1_val = $urandom; rs2_val = $urandom;
            kill = (c == kill_k);
            #1;
            killed = (kill_k != 0) && (c > kill_k);
            {e_ready, e_rv, e_fl, e_mis} = 4'b1000;
            if (killed)            {e_ready, e_rv, e_fl, e_mis} = 4'b1000;
            else if (c == 1)       {e_ready, e_rv, e_fl, e_mis} = 4'b0000;
            else if (!taken)       {e_ready, e_rv, e_fl, e_mis} = 4'b1000;
            else if (mis)          {e_ready, e_rv, e_fl, e_mis} = (c == 2) ? 4'b1001 : 4'b1000;
            else if (c == 2)       {e_ready, e_rv, e_fl, e_mis} = 4'b0110;
            else if (c <= 1 + FC)  {e_ready, e_rv, e_fl, e_mis} = 4'b0010;
            if (c == kill_k) e_ready = 1'b0;
            if (c == 2 && taken && !mis && (kill_k == 0 || kill_k >= 2)) exp_count = exp_count + 1;
            if (c == 1) begin
                chk_eq("cmp_in_0", cmp_in_0, a);
                chk_eq("cmp_in_1", cmp_in_1, b);
                chk_eq("cmp_mode", {29'd0, cmp_mode}, {29'd0, mode});
            end
            chk_eq($sformatf("br_ready_c%0d", c), br_ready, e_ready);
            chk_eq($sformatf("redirect_valid_c%0d", c), redirect_valid, e_rv);
            chk_eq($sformatf("flush_c%0d", c), flush, e_fl);
            chk_eq($sformatf("misalign_c%0d", c), misalign, e_mis);
            chk_eq("taken_count", taken_count, exp_count);
            if (e_rv) chk_eq("redirect_pc", redirect_pc, tgt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  m;
        logic [31:0] a, b, o;
        int          k;
        rst_n = 1'b0; br_valid = 1'b0; br_mode = '0; br_jump = 1'b0; br_jalr = 1'b0;
        br_pc = '0; br_offset = '0; rs1_val = '0; rs2_val = '0; kill = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_eq("rst_ready", br_ready, 0);
        chk_eq("rst_redirect_valid", redirect_valid, 0);
        chk_eq("rst_redirect_pc", redirect_pc, 0);
        chk_eq("rst_flush", flush, 0);
        chk_eq("rst_misalign", misalign, 0);
        chk_eq("rst_count", taken_count, 0);
        chk_eq("rst_cmp_in_0", cmp_in_0, 0);
        chk_eq("rst_cmp_mode", {29'd0, cmp_mode}, 0);
        @(negedge clk); rst_n = 1'b1;

        run_br(3'b000, 0, 0, 32'h100, 32'h20, 32'd5, 32'd5, 0);
        chk_eq("beq_count", taken_count, 1);
        run_br(3'b100, 0, 0, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 0);
        run_br(3'b110, 0, 0, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 0);
        run_br(3'b000, 1, 1, 32'h400, 32'h4, 32'h1003, 32'd0, 0);
        run_br(3'b000, 1, 1, 32'h400, 32'h3, 32'h1001, 32'd0, 0);
        run_br(3'b010, 1, 0, 32'hFFFF_FFF0, 32'h20, 32'd9, 32'd3, 0);
        run_br(3'b011, 0, 0, 32'h500, 32'h8, 32'd4, 32'd4, 0);
        run_br(3'b001, 0, 0, 32'h600, 32'h10, 32'd1, 32'd2, 1);
        run_br(3'b001, 0, 0, 32'h600, 32'h10, 32'd1, 32'd2, 2);
        run_br(3'b001, 0, 0, 32'h600, 32'h10, 32'd1, 32'd2, 3);

        // kill with a valid request in IDLE must not accept it
        @(negedge clk);
        br_valid = 1'b1; kill = 1'b1; rs1_val = 32'hDEAD_BEEF; br_mode = 3'b000; br_jump = 1'b1;
        #1 chk_eq("kill_idle_ready", br_ready, 0);
        @(negedge clk);
        br_valid = 1'b0; kill = 1'b0;
        #1 chk_eq("kill_idle_ready_after", br_ready, 1);
        chk_eq("kill_idle_no_latch", cmp_in_0, 32'd1);

        // asynchronous reset while in FLUSH, request held across release
        @(negedge clk);
        br_valid = 1'b1; br_mode = 3'b000; br_jump = 1'b0; br_jalr = 1'b0;
        br_pc = 32'h200; br_offset = 32'h40; rs1_val = 32'd7; rs2_val = 32'd7;
        repeat (3) @(negedge clk);
        #1 chk_eq("pre_rst_flush", flush, 1);
        rst_n = 1'b0;
        #1;
        chk_eq("async_rst_flush", flush, 0);
        chk_eq("async_rst_rv", redirect_valid, 0);
        chk_eq("async_rst_count", taken_count, 0);
        chk_eq("async_rst_ready", br_ready, 0);
        exp_count = 0;
        @(negedge clk); rst_n = 1'b1;
        #1 chk_eq("rel_ready", br_ready, 1);
        @(negedge clk); br_valid = 1'b0;
        #1 chk_eq("rel_accept_cmp", cmp_in_0, 32'd7);
        chk_eq("rel_compare_ready", br_ready, 0);
        #1;
        @(negedge clk);
        #1 chk_eq("rel_redirect_pc", redirect_pc, 32'h240);
        chk_eq("rel_redirect_valid", redirect_valid, 1);
        exp_count = 1;
        repeat (FC) @(negedge clk);
        #1 chk_eq("rel_done_ready", br_ready, 1);
        chk_eq("rel_count", taken_count, exp_count);

        for (int i = 0; i < 150; i++) begin
            m = 3'($urandom);
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            o = $urandom;
            if ($urandom_range(0, 1) == 1) o[1:0] = 2'b00;
            k = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 1 + FC) : 0;
            run_br(m, ($urandom_range(0, 3) == 0), 1'($urandom), $urandom & 32'hFFFF_FFFC, o, a, b, k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
